// File: rtl/fr_pkg.sv
// Shared widths, result layout and result classification for the fr_normalize pipeline.
package fr_pkg;

   localparam int MANT_W = 24;
   localparam int EXP_W  = 8;
   localparam logic [EXP_W-1:0] EXP_MAX = {EXP_W{1'b1}};

   typedef struct packed {
      logic              sign;
      logic [EXP_W-1:0]  exp;
      logic [MANT_W-2:0] frac;
   } fr_float_t;

   typedef enum logic [1:0] {
      KIND_NORM    = 2'd0,
      KIND_ZERO    = 2'd1,
      KIND_UFLOW   = 2'd2,
      KIND_SPECIAL = 2'd3
   } fr_kind_e;

   // Inf/NaN wins over everything, then a true zero, then flush-to-zero on underflow.
   function automatic fr_kind_e fr_classify(input logic is_special,
                                            input logic mant_zero,
                                            input logic exp_le_zero);
      fr_kind_e kind_v;
      if (is_special) begin
         kind_v = KIND_SPECIAL;
      end else if (mant_zero) begin
         kind_v = KIND_ZERO;
      end else if (exp_le_zero) begin
         kind_v = KIND_UFLOW;
      end else begin
         kind_v = KIND_NORM;
      end
      return kind_v;
   endfunction

endpackage

// File: rtl/fr_lshift.sv
// Combinational logarithmic barrel shifter, left shift by shamt with zero fill.
module fr_lshift #(
   parameter int W    = 23,
   parameter int SH_W = 5
) (
   input  logic [W-1:0]    data,
   input  logic [SH_W-1:0] shamt,
   output logic [W-1:0]    shifted
);

   logic [W-1:0] stage_s;

   // Stage i moves the word by 2**i positions when shamt[i] is set.
   always_comb begin
      stage_s = data;
      for (int i = 0; i < SH_W; i++) begin
         if (shamt[i]) begin
            stage_s = stage_s << (32'd1 << i);
         end else begin
            stage_s = stage_s;
         end
      end
   end

   assign shifted = stage_s;

endmodule

// File: rtl/fr_normalize.sv
// Two-stage float normalizer: aligns operands with the registered leading-one count, then shifts.
// Optional FR_NORM_STATS_EN adds a saturating underflow counter output (uflow_cnt).
module fr_normalize #(
   parameter int MANT_W = fr_pkg::MANT_W,
   parameter int EXP_W  = fr_pkg::EXP_W
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    in_valid,
   input  logic                    in_sign,
   input  logic [EXP_W-1:0]        in_exp,
   input  logic [MANT_W-1:0]       nor_input,
   input  logic [7:0]              count,
   output logic                    out_valid,
   output logic [EXP_W+MANT_W-1:0] result,
   output logic                    out_zero,
   output logic                    out_uflow
`ifdef FR_NORM_STATS_EN
   ,
   output logic [15:0]             uflow_cnt
`endif
);

   import fr_pkg::*;

   localparam int SH_W  = $clog2(MANT_W);
   localparam int XW    = EXP_W + 1;
   localparam int RES_W = EXP_W + MANT_W;
   localparam logic [EXP_W-1:0] EXP_ONES = {EXP_W{1'b1}};
   localparam logic [7:0]       TOP_IDX  = 8'(MANT_W - 1);

   logic                  armed_r;
   logic                  s1_valid_r;
   logic                  s1_sign_r;
   logic [EXP_W-1:0]      s1_exp_r;
   logic [MANT_W-1:0]     s1_mant_r;

   logic [SH_W-1:0]       shift_s;
   logic signed [XW-1:0]  exp_diff_s;
   logic [MANT_W-2:0]     frac_s;
   logic                  mant_zero_s;
   logic                  le_zero_s;
   fr_kind_e              kind_s;
   logic [RES_W-1:0]      nxt_result_s;
   logic                  nxt_zero_s;
   logic                  nxt_uflow_s;

   // Stays low through the release cycle so inputs seen then are never accepted.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         armed_r <= 1'b0;
      end else begin
         armed_r <= 1'b1;
      end
   end

   // Stage 1: free-running capture so operands line up with the detector's count.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         s1_valid_r <= 1'b0;
         s1_sign_r  <= 1'b0;
         s1_exp_r   <= {EXP_W{1'b0}};
         s1_mant_r  <= {MANT_W{1'b0}};
      end else begin
         s1_valid_r <= in_valid & armed_r;
         s1_sign_r  <= in_sign;
         s1_exp_r   <= in_exp;
         s1_mant_r  <= nor_input;
      end
   end

   // Shift distance from the leading-one index; out-of-range counts mean no shift.
   always_comb begin
      if (count > TOP_IDX) begin
         shift_s = {SH_W{1'b0}};
      end else begin
         shift_s = SH_W'(TOP_IDX - count);
      end
   end

   assign exp_diff_s  = $signed({1'b0, s1_exp_r}) - $signed(XW'(shift_s));
   assign mant_zero_s = (s1_mant_r == {MANT_W{1'b0}});
   assign le_zero_s   = exp_diff_s[XW-1] | (exp_diff_s == {XW{1'b0}});
   assign kind_s      = fr_classify(s1_exp_r == EXP_ONES, mant_zero_s, le_zero_s);

   // The hidden bit is dropped anyway, so only the fraction bits need shifting.
   fr_lshift #(
      .W    (MANT_W - 1),
      .SH_W (SH_W)
   ) u_lshift (
      .data    (s1_mant_r[MANT_W-2:0]),
      .shamt   (shift_s),
      .shifted (frac_s)
   );

   // Next output word and flags; empty slots carry all zeros.
   always_comb begin
      nxt_result_s = {RES_W{1'b0}};
      nxt_zero_s   = 1'b0;
      nxt_uflow_s  = 1'b0;
      if (s1_valid_r) begin
         case (kind_s)
            KIND_SPECIAL: begin
               nxt_result_s = {s1_sign_r, s1_exp_r, s1_mant_r[MANT_W-2:0]};
            end
            KIND_ZERO: begin
               nxt_result_s = {s1_sign_r, {(RES_W-1){1'b0}}};
               nxt_zero_s   = 1'b1;
            end
            KIND_UFLOW: begin
               nxt_result_s = {s1_sign_r, {(RES_W-1){1'b0}}};
               nxt_zero_s   = 1'b1;
               nxt_uflow_s  = 1'b1;
            end
            KIND_NORM: begin
               nxt_result_s = {s1_sign_r, exp_diff_s[EXP_W-1:0], frac_s};
            end
            default: begin
               nxt_result_s = {RES_W{1'b0}};
            end
         endcase
      end else begin
         nxt_result_s = {RES_W{1'b0}};
      end
   end

   // Stage 2: registered outputs.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         out_valid <= 1'b0;
         result    <= {RES_W{1'b0}};
         out_zero  <= 1'b0;
         out_uflow <= 1'b0;
      end else begin
         out_valid <= s1_valid_r;
         result    <= nxt_result_s;
         out_zero  <= nxt_zero_s;
         out_uflow <= nxt_uflow_s;
      end
   end

`ifdef FR_NORM_STATS_EN
   // Saturating count of flushed results.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         uflow_cnt <= 16'h0000;
      end else if (out_valid && out_uflow && (uflow_cnt != 16'hFFFF)) begin
         uflow_cnt <= uflow_cnt + 16'h0001;
      end else begin
         uflow_cnt <= uflow_cnt;
      end
   end
`endif

endmodule

// File: tb/tb_fr_normalize.sv
// Randomized self-checking bench for fr_normalize against a behavioural float model.
module tb_fr_normalize;

   import fr_pkg::*;

   localparam int NIN = 300;
   localparam int NT  = NIN + 3;

   logic        clock     = 1'b0;
   logic        reset     = 1'b1;
   logic        in_valid  = 1'b0;
   logic        in_sign   = 1'b0;
   logic [7:0]  in_exp    = 8'd0;
   logic [23:0] nor_input = 24'd0;
   logic [7:0]  count     = 8'd0;
   logic        out_valid;
   logic [31:0] result;
   logic        out_zero;
   logic        out_uflow;
`ifdef FR_NORM_STATS_EN
   logic [15:0] uflow_cnt;
   logic [15:0] cnt_model = 16'd0;
`endif

   logic        v_a [NT];
   logic        s_a [NT];
   logic [7:0]  e_a [NT];
   logic [23:0] m_a [NT];
   logic [7:0]  c_a [NT];
   logic        r_a [NT];
   logic        d_en [NT];
   logic [31:0] d_res [NT];
   logic [1:0]  d_flg [NT];

   int n_checks = 0;
   int n_errors = 0;

   fr_normalize dut (
      .clock     (clock),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_sign   (in_sign),
      .in_exp    (in_exp),
      .nor_input (nor_input),
      .count     (count),
      .out_valid (out_valid),
      .result    (result),
      .out_zero  (out_zero),
      .out_uflow (out_uflow)
`ifdef FR_NORM_STATS_EN
      ,
      .uflow_cnt (uflow_cnt)
`endif
   );

   always #5 clock = ~clock;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] req);
      n_checks++;
      if (obs !== req) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, req, $time);
      end
   endtask

   // Returns {zero, uflow, result} for one operand set, straight from the number rules.
   function automatic logic [33:0] ref_norm(input logic sg, input logic [7:0] ex,
                                            input logic [23:0] mt, input logic [7:0] ct);
      int        sh;
      int        e;
      longint    p;
      fr_float_t f;
      sh     = (ct > 8'd23) ? 0 : 23 - int'(ct);
      f.sign = sg;
      f.exp  = 8'd0;
      f.frac = 23'd0;
      if (ex == 8'hFF) begin
         f.exp  = ex;
         f.frac = mt[22:0];
         return {2'b00, f};
      end
      if (mt == 24'd0) return {2'b10, f};
      e = int'(ex) - sh;
      if (e <= 0) return {2'b11, f};
      p      = longint'(mt) * (longint'(1) << sh);
      f.exp  = 8'(e);
      f.frac = 23'(p % (longint'(1) << 23));
      return {2'b00, f};
   endfunction

   // An input yields output only if no reset overlaps its flight or its cycle follows a release.
   function automatic logic eff_valid(input int j);
      if (j < 0) return 1'b0;
      if (!v_a[j] || r_a[j] || r_a[j+1] || r_a[j+2]) return 1'b0;
      if (j > 0) begin
         if (r_a[j-1]) return 1'b0;
      end
      return 1'b1;
   endfunction

   task automatic set_in(input int k, input logic v, input logic s, input logic [7:0] e,
                         input logic [23:0] m, input logic [7:0] c);
      v_a[k] = v; s_a[k] = s; e_a[k] = e; m_a[k] = m; c_a[k] = c;
   endtask

   task automatic gen_rand(input int k);
      int          sel;
      int          p;
      logic [7:0]  e;
      logic [23:0] m;
      logic [7:0]  c;
      sel = $urandom_range(0, 9);
      if (sel < 2) e = 8'($urandom_range(0, 30));
      else if (sel == 2) e = 8'hFF;
      else e = 8'($urandom_range(1, 254));
      if (($urandom_range(0, 11) == 0) && (e != 8'hFF)) begin
         m = 24'd0;
         c = 8'($urandom_range(0, 255));
      end else begin
         p = $urandom_range(0, 23);
         m = 24'((32'd1 << p) | ($urandom & ((32'd1 << p) - 32'd1)));
         c = 8'(p);
         if ($urandom_range(0, 11) == 0) c = 8'($urandom_range(24, 255));
      end
      set_in(k, ($urandom_range(0, 9) != 0), 1'($urandom_range(0, 1)), e, m, c);
   endtask

   initial begin
      logic [33:0] exp_v;
      logic        ev;
      int          j;

      for (int k = 0; k < NT; k++) begin
         set_in(k, 1'b0, 1'b0, 8'd0, 24'd0, 8'd0);
         r_a[k] = 1'b0; d_en[k] = 1'b0; d_res[k] = 32'd0; d_flg[k] = 2'b00;
      end
      r_a[0] = 1'b1;
      r_a[1] = 1'b1;

      set_in(3, 1'b1, 1'b0, 8'd127, 24'h800000, 8'd23);
      d_en[3] = 1'b1; d_res[3] = 32'h3F800000; d_flg[3] = 2'b00;
      set_in(4, 1'b1, 1'b0, 8'd130, 24'h000001, 8'd0);
      d_en[4] = 1'b1; d_res[4] = 32'h35800000; d_flg[4] = 2'b00;
      set_in(5, 1'b1, 1'b1, 8'd5, 24'h000100, 8'd8);
      d_en[5] = 1'b1; d_res[5] = 32'h80000000; d_flg[5] = 2'b11;
      set_in(6, 1'b1, 1'b1, 8'd64, 24'h000000, 8'd23);
      d_en[6] = 1'b1; d_res[6] = 32'h80000000; d_flg[6] = 2'b10;
      set_in(7, 1'b1, 1'b0, 8'd255, 24'hC00000, 8'd23);
      d_en[7] = 1'b1; d_res[7] = 32'h7FC00000; d_flg[7] = 2'b00;
      set_in(8, 1'b1, 1'b0, 8'd200, 24'h000F00, 8'd200);
      d_en[8] = 1'b1; d_res[8] = 32'h64000F00; d_flg[8] = 2'b00;
      set_in(9, 1'b0, 1'b0, 8'd50, 24'hABCDEF, 8'd3);

      for (int k = 12; k < 22; k++) begin
         gen_rand(k);
         v_a[k] = 1'b1;
      end
      r_a[16] = 1'b1;
      for (int k = 24; k < NIN; k++) gen_rand(k);
      r_a[150] = 1'b1;
      r_a[151] = 1'b1;

      for (int k = 0; k < NT; k++) begin
         @(posedge clock);
         #1;
         reset     = r_a[k];
         in_valid  = v_a[k];
         in_sign   = s_a[k];
         in_exp    = e_a[k];
         nor_input = m_a[k];
         count     = (k > 0) ? c_a[k-1] : 8'd0;
         @(negedge clock);
         j  = k - 2;
         ev = eff_valid(j);
         exp_v = ev ? ref_norm(s_a[j], e_a[j], m_a[j], c_a[j]) : 34'd0;
         check_eq("out_valid", 64'(out_valid), 64'(ev));
         check_eq("result",    64'(result),    64'(exp_v[31:0]));
         check_eq("out_zero",  64'(out_zero),  64'(exp_v[33]));
         check_eq("out_uflow", 64'(out_uflow), 64'(exp_v[32]));
         if (ev && d_en[j]) begin
            check_eq("directed_result", 64'(result), 64'(d_res[j]));
            check_eq("directed_flags",  64'({out_zero, out_uflow}), 64'(d_flg[j]));
         end
`ifdef FR_NORM_STATS_EN
         if (r_a[k]) cnt_model = 16'd0;
         check_eq("uflow_cnt", 64'(uflow_cnt), 64'(cnt_model));
         if (ev && exp_v[32] && (cnt_model != 16'hFFFF)) cnt_model = cnt_model + 16'd1;
`endif
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/fr_normalize.md
FR_NORMALIZE -- requirements
Module: fr_normalize

Interface
REQ-001 SHALL have parameter MANT_W, default 24; mantissa width including the hidden-bit position.
REQ-002 SHALL have parameter EXP_W, default 8; biased exponent width.
REQ-003 SHALL have port clock, input, 1; single clock, all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1; asynchronous, active-high reset.
REQ-005 SHALL have port in_valid, input, 1; qualifies in_sign, in_exp and nor_input in the current cycle.
REQ-006 SHALL have port in_sign, input, 1; sign of the unnormalized result.
REQ-007 SHALL have port in_exp, input, EXP_W; biased exponent, valid when bit MANT_W-1 is the leading one.
REQ-008 SHALL have port nor_input, input, MANT_W; unnormalized mantissa, the same vector that drives the leading-one detector.
REQ-009 SHALL have port count, input, 8; leading-one index from the registered detector, arriving one cycle after nor_input.
REQ-010 SHALL have port out_valid, output, 1; qualifies result and flags.
REQ-011 SHALL have port result, output, 1+EXP_W+MANT_W-1; packed {sign, exponent, fraction without hidden bit}.
REQ-012 SHALL have port out_zero, output, 1; result is a signed zero.
REQ-013 SHALL have port out_uflow, output, 1; result was flushed to zero by exponent underflow.

Function
REQ-014 Stage 1 SHALL register in_valid, in_sign, in_exp and nor_input every cycle, with no enable, so they align with count.
REQ-015 Stage 2 SHALL compute shift = (MANT_W-1) - count and register the left-shifted mantissa, the exponent and the flags. out_valid SHALL assert exactly 2 cycles after in_valid.
REQ-016 When count > MANT_W-1, shift SHALL be 0.
REQ-017 The exponent SHALL be in_exp - shift, computed EXP_W+1 bits wide and signed.
REQ-018 A zero mantissa (all nor_input bits 0) SHALL yield result = {in_sign, 0, 0} with out_zero=1 and out_uflow=0, whatever count is.
REQ-019 When in_exp - shift <= 0 and the mantissa is nonzero, the output SHALL be {in_sign, 0, 0}, out_zero=1, out_uflow=1 (flush-to-zero, no denormals).
REQ-020 in_exp = all-ones (Inf/NaN) SHALL pass through with the fraction equal to nor_input[MANT_W-2:0], no shift applied, and both flags 0.
REQ-021 There is no backpressure: a new input SHALL be accepted every cycle, giving a throughput of 1 per cycle.
REQ-022 Stages holding valid=0 SHALL hold result and flags at 0.

Reset
REQ-023 While reset=1, every pipeline register, out_valid, result, out_zero, out_uflow and any statistics counter SHALL be 0.
REQ-024 Reset asserted mid-operation SHALL discard in-flight data. No out_valid SHALL appear for inputs presented during reset or during the cycle of its release.

Configuration
REQ-025 When macro FR_NORM_STATS_EN is defined, the block SHALL add output uflow_cnt (16 bits).
REQ-026 uflow_cnt SHALL increment when out_valid and out_uflow are both 1, and SHALL saturate at 16'hFFFF.
REQ-027 Without FR_NORM_STATS_EN, no counter logic and no uflow_cnt port SHALL exist.

Structure
REQ-028 Package fr_pkg SHALL hold MANT_W, EXP_W, EXP_MAX (all-ones exponent) and a packed float result typedef.
REQ-029 The shifter SHALL be a sub-module, fr_lshift (combinational barrel left shift by 0..MANT_W-1), instanced once in stage 2.

Verification
REQ-030 nor_input=24'h800000, in_exp=127, count=23 -> 2 cycles later result=32'h3F800000, flags 0.
REQ-031 nor_input=24'h000001, in_exp=130, count=0 -> exponent 107, fraction 0, result=32'h35800000.
REQ-032 nor_input=24'h000100, in_exp=5, count=8 (shift 15) -> result={sign,0,0}, out_uflow=1, out_zero=1; the counter increments when FR_NORM_STATS_EN is defined.
REQ-033 nor_input=0, count=23, in_sign=1 -> result=32'h80000000, out_zero=1, out_uflow=0.
REQ-034 Back-to-back valid inputs for 10 cycles, with reset pulsed for 1 cycle at cycle 4 -> out_valid low through the cycle after release, outputs resume 2 cycles after the first post-reset input.
REQ-035 in_exp=255, nor_input=24'hC00000 -> result=32'h7FC00000 (NaN passthrough), flags 0.
